// File: rtl/spi_slave_regif_if.sv
// Register-file bus of the SPI slave: write strobe/address/data plus read request/response.
// The "master" modport is the SPI slave side that issues requests; "slave" is the register file.
interface spi_slave_regif_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [DATA_W-1:0] o_wr_data;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0] i_rd_data;

  modport master (
    output o_wr_en, o_wr_addr, o_wr_data, o_rd_en, o_rd_addr,
    input  i_rd_data
  );

  modport slave (
    input  o_wr_en, o_wr_addr, o_wr_data, o_rd_en, o_rd_addr,
    output i_rd_data
  );
endinterface

// File: rtl/spi_slave_regif.sv
// SPI mode 0 slave (cmd/addr/payload frame) driving a register-file bus, oversampled on sysclk.
// Define SPI_SLAVE_ERR_EN to add the sticky o_err flag.
module spi_slave_regif #(
  parameter int               CMD_W     = 8,
  parameter int               ADDR_W    = 8,
  parameter int               DATA_W    = 16,
  parameter logic [CMD_W-1:0] CMD_WRITE = 8'h02,
  parameter logic [CMD_W-1:0] CMD_READ  = 8'h03
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  output logic o_busy,
  spi_slave_regif_if.master regbus
`ifdef SPI_SLAVE_ERR_EN
  ,
  output logic o_err
`endif
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

  state_t            state;
  logic              sclk_s1, sclk_s2, sclk_d;
  logic              cs_s1, cs_s2, cs_d;
  logic              mosi_s1, mosi_s2;
  logic              sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] rx_sr;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_sr;
  logic [CMD_W-1:0]  opcode;
  logic [ADDR_W-1:0] addr;
  logic              rd_pend;
  logic              cmd_last, addr_last, data_last;

  // Two-flop synchronizers plus one delay stage for edge detection; idle values match a quiet bus.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign cs_rise   = cs_s2 & ~cs_d;
  assign cs_fall   = ~cs_s2 & cs_d;
  assign rx_next   = {rx_sr, mosi_s2};
  assign cmd_last  = (bit_cnt == CNT_W'(CMD_W - 1));
  assign addr_last = (bit_cnt == CNT_W'(ADDR_W - 1));
  assign data_last = (bit_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      miso             <= 1'b0;
      o_busy           <= 1'b0;
      bit_cnt          <= '0;
      rx_sr            <= '0;
      tx_sr            <= '0;
      opcode           <= '0;
      addr             <= '0;
      rd_pend          <= 1'b0;
      regbus.o_wr_en   <= 1'b0;
      regbus.o_wr_addr <= '0;
      regbus.o_wr_data <= '0;
      regbus.o_rd_en   <= 1'b0;
      regbus.o_rd_addr <= '0;
    end else begin
      regbus.o_wr_en <= 1'b0;
      regbus.o_rd_en <= 1'b0;
      rd_pend        <= regbus.o_rd_en;
      // Read data arrives the cycle after the request; it is loaded well before the first payload fall.
      if (rd_pend && state == DATA) begin
        tx_sr <= regbus.i_rd_data;
      end
      if (cs_rise && state != IDLE) begin
        state   <= IDLE;
        o_busy  <= 1'b0;
        miso    <= 1'b0;
        bit_cnt <= '0;
        rx_sr   <= '0;
        tx_sr   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= CMD;
              o_busy  <= 1'b1;
              miso    <= 1'b0;
              bit_cnt <= '0;
              rx_sr   <= '0;
              tx_sr   <= '0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              rx_sr <= rx_next[DATA_W-2:0];
              if (cmd_last) begin
                opcode  <= rx_next[CMD_W-1:0];
                bit_cnt <= '0;
                state   <= ADDR;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ADDR: begin
            if (sclk_rise) begin
              rx_sr <= rx_next[DATA_W-2:0];
              if (addr_last) begin
                addr    <= rx_next[ADDR_W-1:0];
                bit_cnt <= '0;
                state   <= DATA;
                if (opcode == CMD_READ) begin
                  regbus.o_rd_en   <= 1'b1;
                  regbus.o_rd_addr <= rx_next[ADDR_W-1:0];
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              rx_sr <= rx_next[DATA_W-2:0];
              if (data_last) begin
                bit_cnt <= '0;
                state   <= DONE;
                miso    <= 1'b0;
                if (opcode == CMD_WRITE) begin
                  regbus.o_wr_en   <= 1'b1;
                  regbus.o_wr_addr <= addr;
                  regbus.o_wr_data <= rx_next;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (sclk_fall && opcode == CMD_READ) begin
              miso  <= tx_sr[DATA_W-1];
              tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
          end
          DONE: begin
            miso <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef SPI_SLAVE_ERR_EN
  logic err_set, err_clr;

  // A frame completed as a write to the all-ones address acknowledges and clears the error.
  assign err_set = (cs_rise && (state inside {CMD, ADDR, DATA}))
                 || (!cs_rise && state == CMD && sclk_rise && cmd_last
                     && rx_next[CMD_W-1:0] != CMD_WRITE && rx_next[CMD_W-1:0] != CMD_READ)
                 || (!cs_rise && state == DONE && sclk_rise);
  assign err_clr = !cs_rise && state == DATA && sclk_rise && data_last
                 && opcode == CMD_WRITE && addr == {ADDR_W{1'b1}};

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      o_err <= 1'b0;
    end else if (err_set) begin
      o_err <= 1'b1;
    end else if (err_clr) begin
      o_err <= 1'b0;
    end
  end
`endif

endmodule
